// File: rtl/dds_pkg.sv
// Shared definitions for the DDS waveform generator: mode encodings,
// default widths and the midscale helper used for the idle output level.
package dds_pkg;

  typedef enum logic [1:0] {
    MODE_SAW = 2'd0,
    MODE_TRI = 2'd1,
    MODE_SQR = 2'd2,
    MODE_SIN = 2'd3
  } dds_mode_e;

  localparam int ACC_W_DEF  = 32;
  localparam int OUT_W_DEF  = 8;
  localparam int LUT_AW_DEF = 8;

  // Offset-binary zero: only the MSB of a w-bit sample set.
  function automatic int unsigned midscale(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine table with a registered read port. Entry i holds
// round((2^(OUT_W-1)-1) * sin(pi/2 * i / 2^LUT_AW)), built at elaboration.
module sine_quarter_rom #(
  parameter int LUT_AW = 8,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic [LUT_AW-1:0] addr,
  output logic [OUT_W-1:0]  data
);

  localparam int  DEPTH = 2 ** LUT_AW;
  localparam real HALF_PI = 3.14159265358979323846 / 2.0;
  localparam real AMP = (2.0 ** (OUT_W - 1)) - 1.0;

  logic [OUT_W-1:0] table_w [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam real ANG = HALF_PI * i / (2.0 ** LUT_AW);
    localparam int  VAL = $rtoi(AMP * $sin(ANG) + 0.5);
    assign table_w[i] = OUT_W'(VAL);
  end

  logic [OUT_W-1:0] data_q;

  always_ff @(posedge clk) begin
    data_q <= table_w[addr];
  end

  assign data = data_q;

endmodule

// File: rtl/dds_waveform_gen.sv
// Direct-digital-synthesis generator: phase accumulator (stage 1) followed by
// a registered shaping stage (stage 2) producing saw/triangle/square/sine.
module dds_waveform_gen
  import dds_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int LUT_AW = LUT_AW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sync_clear,
  input  logic [ACC_W-1:0] increment,
  input  logic [1:0]       mode,
  input  logic [OUT_W-1:0] duty,
  output logic [OUT_W-1:0] waveform,
  output logic             waveform_valid,
  output logic             cycle_start
);

  localparam logic [OUT_W-1:0] MID = OUT_W'(midscale(OUT_W));

  // Stage 1 state
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             v1_q, v1_d;
  logic             c1_q, c1_d;
  dds_mode_e        mode_act_q, mode_act_d;
  logic [OUT_W-1:0] duty_act_q, duty_act_d;

  // Stage 2 state
  logic [OUT_W-1:0] shaped_q, shaped_d;
  logic             is_sine_q, is_sine_d;
  logic             sine_neg_q, sine_neg_d;
  logic             valid_q, cs_q;

  logic [ACC_W:0]   sum;
  logic             latch;

  // Mode and duty only move at wrap (or while idle) so a period is never
  // split between two shapes.
  always_comb begin
    sum        = {1'b0, acc_q} + {1'b0, increment};
    acc_d      = acc_q;
    v1_d       = 1'b0;
    c1_d       = 1'b0;
    latch      = 1'b0;
    if (sync_clear) begin
      acc_d = '0;
      latch = 1'b1;
    end else if (enable) begin
      acc_d = sum[ACC_W-1:0];
      v1_d  = 1'b1;
      c1_d  = sum[ACC_W];
      latch = sum[ACC_W];
    end else begin
      latch = 1'b1;
    end
    mode_act_d = latch ? dds_mode_e'(mode) : mode_act_q;
    duty_act_d = latch ? duty : duty_act_q;
  end

  logic [OUT_W-1:0]  saw_s;
  logic [OUT_W-1:0]  tri_s;
  logic              tri_t;
  logic [1:0]        quad;
  logic [LUT_AW-1:0] lut_a;
  logic [LUT_AW-1:0] rom_addr;
  logic [OUT_W-1:0]  rom_data;

  always_comb begin
    saw_s      = acc_q[ACC_W-1 -: OUT_W];
    tri_t      = acc_q[ACC_W-1];
    tri_s      = acc_q[ACC_W-2 -: OUT_W];
    quad       = acc_q[ACC_W-1 -: 2];
    lut_a      = acc_q[ACC_W-3 -: LUT_AW];
    rom_addr   = quad[0] ? ~lut_a : lut_a;
    shaped_d   = MID;
    is_sine_d  = 1'b0;
    sine_neg_d = quad[1];
    if (v1_q) begin
      case (mode_act_q)
        MODE_SAW: shaped_d = saw_s;
        MODE_TRI: shaped_d = tri_t ? ~tri_s : tri_s;
        MODE_SQR: shaped_d = (saw_s < duty_act_q) ? '1 : '0;
        MODE_SIN: is_sine_d = 1'b1;
        default:  shaped_d = MID;
      endcase
    end
  end

  // The ROM read shares the stage-2 edge, so sine has the same latency as
  // the other shapes; only the quadrant sign is applied after the register.
  sine_quarter_rom #(
    .LUT_AW(LUT_AW),
    .OUT_W (OUT_W)
  ) u_rom (
    .clk (clk),
    .addr(rom_addr),
    .data(rom_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= '0;
      v1_q       <= 1'b0;
      c1_q       <= 1'b0;
      mode_act_q <= MODE_SAW;
      duty_act_q <= MID;
      shaped_q   <= MID;
      is_sine_q  <= 1'b0;
      sine_neg_q <= 1'b0;
      valid_q    <= 1'b0;
      cs_q       <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      v1_q       <= v1_d;
      c1_q       <= c1_d;
      mode_act_q <= mode_act_d;
      duty_act_q <= duty_act_d;
      shaped_q   <= shaped_d;
      is_sine_q  <= is_sine_d;
      sine_neg_q <= sine_neg_d;
      valid_q    <= v1_q;
      cs_q       <= c1_q;
    end
  end

  // Output contract: a sample is meaningful only while waveform_valid is
  // high; when low, waveform sits at midscale. There is no back-pressure.
  assign waveform       = is_sine_q ? (sine_neg_q ? MID - rom_data : MID + rom_data)
                                    : shaped_q;
  assign waveform_valid = valid_q;
  assign cycle_start    = cs_q;

endmodule
